// File: rtl/fios_pkg.sv
// Shared types and default sizing for the FIOS operand server.
package fios_pkg;

    localparam int W_DEFAULT = 17;
    localparam int S_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } serv_state_t;

endpackage

// File: rtl/fios_word_ram.sv
// S x W simple dual-port word store: one write port, one registered read port.
// Array contents have no reset; only the read register is reset.
module fios_word_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 17,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    // Next array contents: single word written when we_i is high.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

    // Read data loads on re_i and holds otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Read register with async reset so the word outputs come up at zero.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fios_operand_server.sv
// Operand/result endpoint between host load/unload logic and PE0 of the DSP chain.
//
//   state | meaning
//   IDLE  | host may load B/P words; start_i launches a multiplication
//   RUN   | serve b_j/p_j fetches, collect result pushes until done_i
//   DRAIN | stream n_res result words to the host over valid/ready
module fios_operand_server
    import fios_pkg::*;
#(
    parameter int S  = S_DEFAULT,
    parameter int W  = W_DEFAULT,
    localparam int AW = $clog2(S),
    localparam int PW = AW + 1
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          load_valid_i,
    input  logic          load_sel_i,
    input  logic [AW-1:0] load_idx_i,
    input  logic [W-1:0]  load_word_i,
    input  logic          start_i,
    output logic          start_o,
    input  logic          b_fetch_i,
    input  logic          p_fetch_i,
    output logic [W-1:0]  b_word_o,
    output logic [W-1:0]  p_word_o,
    input  logic          RES_push_i,
    input  logic [W-1:0]  res_word_i,
    input  logic          done_i,
    output logic          res_valid_o,
    output logic [W-1:0]  res_word_o,
    input  logic          res_ready_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [PW-1:0] S_P  = PW'(S);
    localparam logic [PW-1:0] S_M1 = PW'(S - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    serv_state_t   state_q, state_d;
    logic [PW-1:0] b_ptr_q, b_ptr_d;
    logic [PW-1:0] p_ptr_q, p_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] o_ptr_q, o_ptr_d;
    logic [PW-1:0] n_res_q, n_res_d;
    logic          start_q, start_d;
    logic          err_q, err_d;
    logic          res_valid_q, res_valid_d;

    logic          b_we, p_we, r_we;
    logic          b_re, p_re, r_re;
    logic [AW-1:0] r_raddr;
    logic [PW-1:0] o_next;

    // Next-state, pointer and error logic for the three-state server FSM.
    always_comb begin
        state_d     = state_q;
        b_ptr_d     = b_ptr_q;
        p_ptr_d     = p_ptr_q;
        r_ptr_d     = r_ptr_q;
        o_ptr_d     = o_ptr_q;
        n_res_d     = n_res_q;
        start_d     = 1'b0;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        b_we        = 1'b0;
        p_we        = 1'b0;
        r_we        = 1'b0;
        b_re        = 1'b0;
        p_re        = 1'b0;
        r_re        = 1'b0;
        o_next      = o_ptr_q + ONE;
        r_raddr     = o_ptr_q[AW-1:0];

        case (state_q)
            IDLE: begin
                // The RAM write happens on this edge, so a load alongside start_i lands first.
                if (load_valid_i) begin
                    b_we = !load_sel_i;
                    p_we = load_sel_i;
                end
                if (start_i) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    b_ptr_d = '0;
                    p_ptr_d = '0;
                    r_ptr_d = '0;
                    err_d   = 1'b0;
                end
            end

            RUN: begin
                if (b_fetch_i) begin
                    b_re    = 1'b1;
                    b_ptr_d = (b_ptr_q == S_M1) ? '0 : b_ptr_q + ONE;
                end
                if (p_fetch_i) begin
                    p_re    = 1'b1;
                    p_ptr_d = (p_ptr_q == S_M1) ? '0 : p_ptr_q + ONE;
                end
                if (RES_push_i) begin
                    if (r_ptr_q == S_P) begin
                        err_d = 1'b1;
                    end else begin
                        r_we    = 1'b1;
                        r_ptr_d = r_ptr_q + ONE;
                    end
                end
                if (load_valid_i || start_i) begin
                    err_d = 1'b1;
                end
                // n_res counts a push arriving with done_i.
                if (done_i) begin
                    n_res_d     = r_ptr_d;
                    o_ptr_d     = '0;
                    res_valid_d = 1'b0;
                    if (r_ptr_d == '0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (b_fetch_i || p_fetch_i || RES_push_i) begin
                    err_d = 1'b1;
                end
                // First DRAIN cycle primes the read register so valid rises with its data.
                if (!res_valid_q) begin
                    r_re        = 1'b1;
                    r_raddr     = o_ptr_q[AW-1:0];
                    res_valid_d = 1'b1;
                end else if (res_ready_i) begin
                    o_ptr_d = o_next;
                    if (o_ptr_q == n_res_q - ONE) begin
                        res_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        r_re    = 1'b1;
                        r_raddr = o_next[AW-1:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            b_ptr_q     <= '0;
            p_ptr_q     <= '0;
            r_ptr_q     <= '0;
            o_ptr_q     <= '0;
            n_res_q     <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_ptr_q     <= b_ptr_d;
            p_ptr_q     <= p_ptr_d;
            r_ptr_q     <= r_ptr_d;
            o_ptr_q     <= o_ptr_d;
            n_res_q     <= n_res_d;
            start_q     <= start_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
        end
    end

    fios_word_ram #(.DEPTH(S), .W(W)) u_b_ram (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .we_i     (b_we),
        .waddr_i  (load_idx_i),
        .wdata_i  (load_word_i),
        .re_i     (b_re),
        .raddr_i  (b_ptr_q[AW-1:0]),
        .rdata_o  (b_word_o)
    );

    fios_word_ram #(.DEPTH(S), .W(W)) u_p_ram (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .we_i     (p_we),
        .waddr_i  (load_idx_i),
        .wdata_i  (load_word_i),
        .re_i     (p_re),
        .raddr_i  (p_ptr_q[AW-1:0]),
        .rdata_o  (p_word_o)
    );

    fios_word_ram #(.DEPTH(S), .W(W)) u_r_ram (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .we_i     (r_we),
        .waddr_i  (r_ptr_q[AW-1:0]),
        .wdata_i  (res_word_i),
        .re_i     (r_re),
        .raddr_i  (r_raddr),
        .rdata_o  (res_word_o)
    );

    assign start_o     = start_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

endmodule
